// File: rtl/main_memory_unit.sv
// main_memory_unit: word-addressed data/instruction RAM driven by the control unit.
// Commands are captured from main_memory_c (01 read, 11 write) and committed one
// edge later if the command is still held; memory_word returns registered read data.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (flags and suppresses accesses whose
// address has non-zero bits above the implemented index range).
module main_memory_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        main_memory_c,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] memory_word,
  output logic              busy,
  output logic              mem_error
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [MEM_AW-1:0]   mar;
  logic [DATA_W-1:0]   wdr;
  logic [1:0]          op;
  logic                cmd_valid;
  logic                capture_en;
  logic                access_en;
  logic                write_en;
  logic [DATA_W-1:0]   rd_data;

  logic [DATA_W-1:0]   mem [0:(1 << MEM_AW)-1];

  assign cmd_valid = (main_memory_c == CMD_READ) || (main_memory_c == CMD_WRITE);
  assign busy      = (state == CAPTURE);

  // Next-state decode: capture on a valid command, commit only if it is still held.
  always_comb begin
    state_nxt  = state;
    capture_en = 1'b0;
    access_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          capture_en = 1'b1;
          state_nxt  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (main_memory_c == op) begin
          access_en = 1'b1;
          state_nxt = HOLD;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (main_memory_c == op) begin
          state_nxt = HOLD;
        end else if (cmd_valid) begin
          capture_en = 1'b1;
          state_nxt  = CAPTURE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_BOUNDS_CHECK_EN
  logic oor_q;

  assign write_en = access_en && (op == CMD_WRITE) && !oor_q;
  assign rd_data  = oor_q ? '0 : mem[mar];

  // Out-of-range tracking: classify at capture, latch the sticky error at the access edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oor_q     <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      if (capture_en) begin
        oor_q <= |address[ADDR_W-1:MEM_AW];
      end
      if (access_en && oor_q) begin
        mem_error <= 1'b1;
      end
    end
  end
`else
  logic unused_addr_hi;

  // Upper address bits are deliberately dropped: the index wraps modulo the depth.
  assign unused_addr_hi = ^address[ADDR_W-1:MEM_AW];
  assign write_en       = access_en && (op == CMD_WRITE);
  assign rd_data        = mem[mar];
  assign mem_error      = 1'b0;
`endif

  // State, captured operands and read data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mar         <= '0;
      wdr         <= '0;
      op          <= 2'b00;
      memory_word <= '0;
    end else begin
      state <= state_nxt;
      if (capture_en) begin
        mar <= address[MEM_AW-1:0];
        wdr <= write_data;
        op  <= main_memory_c;
      end
      if (access_en && (op == CMD_READ)) begin
        memory_word <= rd_data;
      end
    end
  end

  // RAM array write port; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[mar] <= wdr;
    end
  end

endmodule

// File: tb/tb_main_memory_unit.sv
// Self-checking bench for main_memory_unit: a command-level reference model is
// compared against the outputs every cycle, plus hand-computed literal checks.
module tb_main_memory_unit;

  logic        clk;
  logic        reset_n;
  logic [1:0]  main_memory_c;
  logic [15:0] address;
  logic [15:0] write_data;
  logic [15:0] memory_word;
  logic        busy;
  logic        mem_error;

  int total;
  int bad;
  int busy_cnt;
  bit chk_en;

  main_memory_unit #(
    .DATA_W(16),
    .ADDR_W(16),
    .MEM_AW(8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .main_memory_c(main_memory_c),
    .address      (address),
    .write_data   (write_data),
    .memory_word  (memory_word),
    .busy         (busy),
    .mem_error    (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a command is armed when first seen, committed when seen again
  // on the next edge, and a committed command held unchanged does nothing more.
  logic [15:0] mm [int];
  logic [15:0] m_word;
  logic        m_err;
  bit          m_armed;
  bit          m_done;
  logic [1:0]  m_op;
  logic [15:0] m_addr;
  logic [15:0] m_data;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_word  = 16'h0000;
      m_err   = 1'b0;
      m_armed = 0;
      m_done  = 0;
      m_op    = 2'b00;
    end else begin
      logic [1:0] c;
      bit         v;
      bit         oor;
      int         idx;
      c = main_memory_c;
      v = (c == 2'b01) || (c == 2'b11);
      if (m_armed) begin
        m_armed = 0;
        if (c == m_op) begin
          idx = int'(m_addr) % 256;
`ifdef MEM_BOUNDS_CHECK_EN
          oor = (int'(m_addr) / 256) != 0;
`else
          oor = 0;
`endif
          if (oor) m_err = 1'b1;
          if (m_op == 2'b01) begin
            if (oor) m_word = 16'h0000;
            else if (mm.exists(idx)) m_word = mm[idx];
            else m_word = 16'h0000;
          end else if (!oor) begin
            mm[idx] = m_data;
          end
          m_done = 1;
        end else begin
          m_done = 0;
        end
      end else if (m_done && c == m_op) begin
        m_done = 1;
      end else begin
        m_done = 0;
        if (v) begin
          m_armed = 1;
          m_op    = c;
          m_addr  = address;
          m_data  = write_data;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (busy) busy_cnt++;
      total++;
      if (memory_word !== m_word) begin
        bad++;
        $display("FAIL cyc_word t=%0t got=%h want=%h", $time, memory_word, m_word);
      end
      total++;
      if (busy !== m_armed) begin
        bad++;
        $display("FAIL cyc_busy t=%0t got=%b want=%b", $time, busy, m_armed);
      end
      total++;
      if (mem_error !== m_err) begin
        bad++;
        $display("FAIL cyc_err t=%0t got=%b want=%b", $time, mem_error, m_err);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Drive a command for n rising edges; returns just after the last edge.
  task automatic apply(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d,
                       input int n);
    main_memory_c = c;
    address       = a;
    write_data    = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    total         = 0;
    bad           = 0;
    busy_cnt      = 0;
    chk_en        = 0;
    reset_n       = 1'b1;
    main_memory_c = 2'b00;
    address       = 16'h0000;
    write_data    = 16'h0000;
    #2 reset_n = 1'b0;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Idle after reset
    apply(2'b00, 16'h0000, 16'h0000, 5);
    check("rst_word", memory_word, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'h0000);
    check("rst_err", {15'd0, mem_error}, 16'h0000);

    // Write then read back, busy one cycle per command
    busy_cnt = 0;
    apply(2'b11, 16'h0005, 16'hBEEF, 3);
    apply(2'b01, 16'h0005, 16'h0000, 3);
    check("rd_beef", memory_word, 16'hBEEF);
    apply(2'b00, 16'h0000, 16'h0000, 1);
    check("busy_cnt2", 16'(busy_cnt), 16'd2);

    // Operand changes during HOLD are ignored: single commit
    apply(2'b11, 16'h0007, 16'h1111, 2);
    address    = 16'h00F0;
    write_data = 16'h2222;
    @(posedge clk); #1;
    apply(2'b00, 16'h0000, 16'h0000, 1);
    apply(2'b01, 16'h0007, 16'h0000, 3);
    check("single_commit", memory_word, 16'h1111);
    apply(2'b00, 16'h0000, 16'h0000, 1);

    // Aborted read and aborted write
    apply(2'b01, 16'h0005, 16'h0000, 1);
    apply(2'b00, 16'h0000, 16'h0000, 2);
    check("abort_rd", memory_word, 16'h1111);
    apply(2'b11, 16'h0005, 16'hDEAD, 1);
    apply(2'b00, 16'h0000, 16'h0000, 2);
    apply(2'b01, 16'h0005, 16'h0000, 3);
    check("abort_wr", memory_word, 16'hBEEF);
    apply(2'b00, 16'h0000, 16'h0000, 1);

    // Back-to-back commands starting from HOLD
    apply(2'b11, 16'h0001, 16'hAAAA, 3);
    apply(2'b00, 16'h0000, 16'h0000, 1);
    apply(2'b11, 16'h0002, 16'h5555, 3);
    apply(2'b01, 16'h0001, 16'h0000, 3);
    check("b2b_aaaa", memory_word, 16'hAAAA);
    apply(2'b11, 16'h0006, 16'h6666, 3);
    apply(2'b01, 16'h0002, 16'h0000, 3);
    check("b2b_5555", memory_word, 16'h5555);
    apply(2'b00, 16'h0000, 16'h0000, 1);

    // A long-held read performs one access; address change is ignored
    apply(2'b01, 16'h0001, 16'h0000, 2);
    address = 16'h0002;
    repeat (4) @(posedge clk); #1;
    check("held_read", memory_word, 16'hAAAA);

    // Command switch inside CAPTURE aborts, then re-captures
    apply(2'b00, 16'h0000, 16'h0000, 1);
    apply(2'b01, 16'h0002, 16'h0000, 1);
    apply(2'b11, 16'h0002, 16'h7777, 3);
    check("switch_abort", memory_word, 16'hAAAA);
    apply(2'b00, 16'h0000, 16'h0000, 1);
    apply(2'b01, 16'h0002, 16'h0000, 3);
    check("switch_wr", memory_word, 16'h7777);

    // Reserved command is idle everywhere
    apply(2'b00, 16'h0000, 16'h0000, 1);
    busy_cnt = 0;
    apply(2'b10, 16'h0001, 16'h0BAD, 3);
    check("rsv_busy", 16'(busy_cnt), 16'd0);
    apply(2'b01, 16'h0001, 16'h0000, 3);
    check("rsv_nowr", memory_word, 16'hAAAA);

    // Reset between capture and commit: no array write
    apply(2'b11, 16'h0009, 16'h0909, 3);
    apply(2'b00, 16'h0000, 16'h0000, 1);
    apply(2'b11, 16'h0009, 16'hFFFF, 1);
    reset_n = 1'b0;
    apply(2'b00, 16'h0000, 16'h0000, 2);
    check("rst_mid_word", memory_word, 16'h0000);
    reset_n = 1'b1;
    apply(2'b00, 16'h0000, 16'h0000, 1);
    apply(2'b01, 16'h0009, 16'h0000, 3);
    check("rst_mid_wr", memory_word, 16'h0909);
    apply(2'b00, 16'h0000, 16'h0000, 1);

    // Upper address bits: wrap or out-of-range
    apply(2'b11, 16'h0003, 16'h3333, 3);
    apply(2'b00, 16'h0000, 16'h0000, 1);
    apply(2'b11, 16'h0103, 16'h1234, 3);
    apply(2'b00, 16'h0000, 16'h0000, 1);
    apply(2'b01, 16'h0003, 16'h0000, 3);
`ifdef MEM_BOUNDS_CHECK_EN
    check("oor_suppr", memory_word, 16'h3333);
    check("oor_err", {15'd0, mem_error}, 16'h0001);
    apply(2'b01, 16'h0103, 16'h0000, 3);
    check("oor_rd0", memory_word, 16'h0000);
`else
    check("wrap_wr", memory_word, 16'h1234);
    check("wrap_err", {15'd0, mem_error}, 16'h0000);
    apply(2'b01, 16'h0103, 16'h0000, 3);
    check("wrap_rd", memory_word, 16'h1234);
`endif
    apply(2'b00, 16'h0000, 16'h0000, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
